// File: rtl/mac_pkg.sv
// Shared widths and the result record for the multiply-accumulate consumer.
// The defaults here match the 64x64 multiplier this block sits behind.
package mac_pkg;

  localparam int PROD_W  = 128;
  localparam int GUARD_W = 8;
  localparam int LAT     = 3;
  localparam int CNT_W   = 16;
  localparam int ACC_W   = PROD_W + GUARD_W;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

endpackage

// File: rtl/res_fifo2.sv
// Two-entry result queue between the accumulator and the consumer handshake.
// The caller never pushes into a full queue unless it pops in the same cycle.
module res_fifo2
  import mac_pkg::*;
#(
  parameter type T = res_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  T           din,
  input  logic       pop,
  output T           dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] cnt
);

  T           mem_q [2];
  T           mem_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_pop;

  assign do_pop = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign cnt   = cnt_q;

endmodule

// File: rtl/mac_accum.sv
// Framed dot-product accumulator fed by a fixed-latency, non-stalling multiplier.
// Issue validity rides a tag pipeline so each product is matched to its operands.
module mac_accum #(
  parameter int PROD_W  = mac_pkg::PROD_W,
  parameter int GUARD_W = mac_pkg::GUARD_W,
  parameter int LAT     = mac_pkg::LAT,
  parameter int CNT_W   = mac_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic [PROD_W-1:0]         prod,
  output logic [PROD_W+GUARD_W-1:0] out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_ovf,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int ACC_W = PROD_W + GUARD_W;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } frame_res_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  logic             issue;
  logic [1:0]       tag_q [LAT];
  logic [1:0]       tag_d [LAT];
  logic             v_al, l_al;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       inflight_q, inflight_d;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             push, pop, fifo_push;
  logic             fifo_full, fifo_empty;
  logic [1:0]       fifo_cnt;
  frame_res_t       push_res, head;

  // Credits come from registered state only, so out_ready never reaches in_ready.
  assign in_ready = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < 3'd2;
  assign issue    = in_valid & in_ready;

  // Issue tags: stage 0 sees the issuing cycle, stage LAT-1 lines up with prod
  always_comb begin
    tag_d[0] = {issue, issue & in_last};
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign v_al = tag_q[LAT-1][1];
  assign l_al = tag_q[LAT-1][0];

  // Accumulate: the extra top bit of the sum is the frame carry-out
  assign sum_ext = {1'b0, acc_q} + {{(GUARD_W+1){1'b0}}, prod};
  assign carry   = sum_ext[ACC_W];

  always_comb begin
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    push_res.data  = sum_ext[ACC_W-1:0];
    push_res.count = sat_inc(cnt_q);
    push_res.ovf   = ovf_q | carry;
    if (v_al) begin
      if (l_al) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = push_res.data;
        cnt_d = push_res.count;
        ovf_d = push_res.ovf;
      end
    end
  end

  assign push      = v_al & l_al;
  assign pop       = out_valid & out_ready;
  assign fifo_push = push & (~fifo_full | pop);

  assign inflight_d = inflight_q + {1'b0, issue & in_last} - {1'b0, push};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= 2'b00;
      end
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      inflight_q <= 2'd0;
    end else begin
      tag_q      <= tag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      inflight_q <= inflight_d;
    end
  end

  // Result queue: out_* always show the head entry
  res_fifo2 #(
    .T(frame_res_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_res),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head.data;
  assign out_count = head.count;
  assign out_ovf   = head.ovf;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum with a behavioural 3-stage multiplier in front
// and a queue of expected frame results checked at every output handshake.
module tb_mac_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, in_ready;
  logic [127:0] prod;
  logic [135:0] out_data;
  logic [15:0]  out_count;
  logic         out_ovf, out_valid, out_ready;

  logic [127:0] a_val, pm0, pm1;

  typedef struct {
    logic [135:0] data;
    logic [15:0]  count;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  logic [159:0] m_sum;
  int           m_cnt;
  int           n_assert = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  mac_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Multiplier stand-in: three register stages, garbage when nothing is issued
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm0  <= '0;
      pm1  <= '0;
      prod <= '0;
    end else begin
      pm0  <= (in_valid && in_ready) ? a_val : {$urandom, $urandom, $urandom, $urandom};
      pm1  <= pm0;
      prod <= pm1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    if (rst === 1'b1) begin
      chk("fifo_overflow", {159'd0, dut.push & dut.fifo_full & ~dut.pop}, 160'd0);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 160'd1, 160'd0);
      end else begin
        e = sb.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e.data});
        chk("out_count", {144'd0, out_count}, {144'd0, e.count});
        chk("out_ovf", {159'd0, out_ovf}, {159'd0, e.ovf});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_el(input logic [127:0] v, input logic last);
    exp_t e;
    in_valid = 1'b1;
    in_last  = last;
    a_val    = v;
    chk("in_ready_at_issue", {159'd0, in_ready}, 160'd1);
    m_sum = m_sum + {32'd0, v};
    m_cnt++;
    if (last) begin
      e.data  = m_sum[135:0];
      e.count = (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
      e.ovf   = (m_sum[159:136] != 0);
      sb.push_back(e);
      m_sum = '0;
      m_cnt = 0;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) tick();
    chk("drain_pending", 160'(sb.size()), 160'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    a_val     = '0;
    m_sum     = '0;
    m_cnt     = 0;
    tick();
    tick();
    chk("rst_out_valid", {159'd0, out_valid}, 160'd0);
    chk("rst_out_data", {24'd0, out_data}, 160'd0);
    chk("rst_out_count", {144'd0, out_count}, 160'd0);
    chk("rst_out_ovf", {159'd0, out_ovf}, 160'd0);
    chk("rst_in_ready", {159'd0, in_ready}, 160'd1);
    rst = 1'b1;
    tick();

    // Frame 5+7+11 with latency of the result pulse
    out_ready = 1'b1;
    issue_el(128'd5, 1'b0);
    issue_el(128'd7, 1'b0);
    issue_el(128'd11, 1'b1);
    chk("lat_edge0", {159'd0, out_valid}, 160'd0);
    tick();
    chk("lat_edge1", {159'd0, out_valid}, 160'd0);
    tick();
    chk("lat_edge2", {159'd0, out_valid}, 160'd0);
    tick();
    chk("lat_edge3", {159'd0, out_valid}, 160'd1);
    tick();
    chk("lat_edge4", {159'd0, out_valid}, 160'd0);
    drain(10);

    // Back-to-back frames {2,3} and {4}
    issue_el(128'd2, 1'b0);
    issue_el(128'd3, 1'b1);
    issue_el(128'd4, 1'b1);
    drain(20);

    // Backpressure: two frames reserve every credit
    out_ready = 1'b0;
    issue_el(128'd9, 1'b1);
    chk("bp_ready_after_first", {159'd0, in_ready}, 160'd1);
    issue_el(128'd10, 1'b1);
    chk("bp_ready_after_second", {159'd0, in_ready}, 160'd0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    a_val    = 128'd99;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_queue_valid", {159'd0, out_valid}, 160'd1);
    chk("bp_ready_held", {159'd0, in_ready}, 160'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", {159'd0, in_ready}, 160'd1);
    chk("bp_second_valid", {159'd0, out_valid}, 160'd1);
    tick();
    chk("bp_empty", {159'd0, out_valid}, 160'd0);
    drain(10);

    // Overflow: 257 all-ones products
    for (int i = 0; i < 256; i++) issue_el({128{1'b1}}, 1'b0);
    issue_el({128{1'b1}}, 1'b1);
    drain(20);

    // Bubbles with garbage on prod
    issue_el(128'd1, 1'b0);
    tick();
    tick();
    issue_el(128'd2, 1'b1);
    drain(20);

    // Reset mid-frame discards everything in flight
    issue_el(128'd5, 1'b0);
    issue_el(128'd5, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {159'd0, out_valid}, 160'd0);
    chk("midrst_in_ready", {159'd0, in_ready}, 160'd1);
    chk("midrst_out_data", {24'd0, out_data}, 160'd0);
    chk("midrst_out_count", {144'd0, out_count}, 160'd0);
    sb.delete();
    m_sum = '0;
    m_cnt = 0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_out_valid", {159'd0, out_valid}, 160'd0);
    chk("post_rst_in_ready", {159'd0, in_ready}, 160'd1);
    issue_el(128'd6, 1'b1);
    drain(20);
    for (int i = 0; i < 4; i++) tick();
    chk("final_idle", {159'd0, out_valid}, 160'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
- Downstream consumer of the 64x64 pipelined multiplier (fixed 3-cycle latency, no valid/stall).
- Tracks operand-issue validity through a tag pipeline matched to the multiplier latency and accumulates the aligned 128-bit products into framed dot-product sums.
- Presents each completed sum through a valid/ready handshake.
- Throttles operand issue with credits, because the multiplier cannot stall.

Parameters:
- PROD_W, 128, product width; equals the multiplier output width.
- GUARD_W, 8, extra accumulator MSBs above PROD_W.
- LAT, 3, multiplier latency in cycles from operand issue to product on prod.
- CNT_W, 16, element-count width.

Ports:
- clk  in  1  clock, shared with the multiplier.
- rst  in  1  asynchronous active-low reset, shared with the multiplier.
- in_valid  in  1  operands are driven to the multiplier this cycle.
- in_last  in  1  this operand pair ends the current frame.
- in_ready  out  1  issue permitted; issue = in_valid & in_ready.
- prod  in  PROD_W  multiplier output c.
- out_data  out  PROD_W+GUARD_W  frame sum.
- out_count  out  CNT_W  number of elements in the frame.
- out_ovf  out  1  accumulator carry-out occurred in the frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears the tag pipeline, accumulator, count, frame ovf, FIFO and in-flight counter.
  - Outputs during reset: out_valid=0, out_data=0, out_count=0, out_ovf=0, in_ready=1.
  - Reset mid-frame discards all partial and queued results. The multiplier shares the reset, so no stale products are tagged valid.
- Tag pipeline:
  - LAT-deep shift of {issue, in_last}.
  - Stage LAT output (v_al, l_al) is aligned with prod: an issue at cycle t is consumed at edge t+LAT.
  - Bubbles (issue=0) shift through as v_al=0; prod is ignored when v_al=0.
- Accumulate on v_al=1:
  - sum = acc + zero-extended prod, computed at PROD_W+GUARD_W+1 bits.
  - The carry bit ORs into the frame ovf. The accumulator keeps the low PROD_W+GUARD_W bits (wraps).
  - Count increments and saturates at 2^CNT_W-1.
- Frame end (v_al=1 and l_al=1):
  - Push {sum, count+1 (saturated), ovf|carry} into the 2-entry result FIFO.
  - Same edge: acc, count and ovf clear to 0, so the next aligned element starts a fresh frame with no gap cycle.
- Single-element frame: count=1, sum=prod.
- Output: out_* are the FIFO head. Pop on out_valid & out_ready. Push and pop in the same cycle are both honoured. Order is preserved.
- Credits:
  - inflight = number of issued in_last tokens not yet pushed.
  - in_ready = (fifo_cnt + inflight) < 2, evaluated from registered state only (no combinational path from out_ready).
  - Issuing with in_last increments inflight; an aligned last decrements it.
  - Simultaneous issue-last, aligned-last and pop all apply in one edge.
- Overflow of the FIFO is impossible by the credit rule; the bench asserts it.
- in_ready is only asserted low when two frames are reserved. Non-last elements of a new frame are also blocked then. This is intentional, to bound buffering.
- No combinational path from prod to outputs. Result latency: aligned last at edge t+LAT → out_valid high from t+LAT (after that edge) when the FIFO was empty.

Decomposition:
- Package mac_pkg:
  - PROD_W, GUARD_W, LAT, CNT_W defaults.
  - ACC_W = PROD_W+GUARD_W.
  - Result struct {data[ACC_W], count[CNT_W], ovf}.
- Sub-module res_fifo2:
  - 2-entry synchronous FIFO of the result struct.
  - Async active-low reset; push/pop/full/empty/cnt.
  - Instantiated once.

Test Plan:
- Frame of 3 products (prod 5, 7, 11; the last flagged), out_ready=1:
  - out_data=23, out_count=3, out_ovf=0.
  - out_valid pulses 1 cycle, exactly LAT edges after the last issue.
- Back-to-back frames:
  - Frame A = {2, 3} then frame B = {4}, issued on consecutive cycles with no gaps.
  - Results in order: (5, 2) then (4, 1); accumulator cleared with no bubble.
- Backpressure:
  - With out_ready=0, issue two single-element frames (values 9, 10); in_ready drops to 0 after the second last.
  - A third issue is refused. Raise out_ready: pops 9, then 10; in_ready returns to 1 after the first pop.
- Overflow:
  - Frame of 2^(GUARD_W)+1 products each equal to 2^128-1.
  - out_ovf=1; out_data equals the true sum mod 2^136.
- Bubbles:
  - Issue 1, idle 2 cycles with garbage on prod, issue 2 (last).
  - out_data=3, out_count=2; garbage is ignored.
- Reset mid-frame:
  - Two elements issued, rst asserted before the last aligns.
  - After release: out_valid=0, in_ready=1. A new frame {6} yields (6, 1) with no residue.
